csi_raw10_unpack: RTL and testbench

//  Converts 2-lane CSI-2 RAW10 packed payload into RAW8 pixel pairs for raw2rgb_8.

---
 rtl/csi_raw10_unpack_pkg.sv | 26 ++
 rtl/csi_raw10_unpack_if.sv | 24 ++
 rtl/csi_raw10_unpack.sv | 98 +++++++++
 tb/tb_csi_raw10_unpack.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/csi_raw10_unpack_pkg.sv
// Shared constants and phase encoding for the CSI-2 RAW10 -> RAW8 unpacker.
package csi_raw10_unpack_pkg;

   localparam int unsigned NUM_LANE            = 2;
   localparam int unsigned WORD_W              = 8 * NUM_LANE;
   localparam int unsigned RAW10_GROUP_WORDS   = 5;
   localparam int unsigned RAW10_GROUP_PIX     = 8;
   localparam int unsigned DEFAULT_LINE_PIXELS = 1280;
   localparam int unsigned DEFAULT_WORDS_IN    =
      DEFAULT_LINE_PIXELS * RAW10_GROUP_WORDS / RAW10_GROUP_PIX;
   localparam int unsigned CNT_W               = $clog2(DEFAULT_WORDS_IN + 1);

   // Position of the current input word inside a 5-word RAW10 group.
   typedef enum logic [2:0] {
      PH0 = 3'd0,
      PH1 = 3'd1,
      PH2 = 3'd2,
      PH3 = 3'd3,
      PH4 = 3'd4
   } phase_t;

   function automatic phase_t phase_next(input phase_t p);
      return (p == PH4) ? PH0 : phase_t'(p + 3'd1);
   endfunction

endpackage

// File: rtl/csi_raw10_unpack_if.sv
// Payload-in / pixel-out bus of the RAW10 unpacker, plus its status flags.
interface csi_raw10_unpack_if;
   import csi_raw10_unpack_pkg::*;

   logic [WORD_W-1:0] data_in;
   logic              data_valid;
   logic [WORD_W-1:0] data_out;
   logic              data_out_valid;
   logic              line_done;
   logic              err_align;
   logic              err_len;
   logic              err_clr;

   modport master (
      output data_in, data_valid, err_clr,
      input  data_out, data_out_valid, line_done, err_align, err_len
   );

   modport slave (
      input  data_in, data_valid, err_clr,
      output data_out, data_out_valid, line_done, err_align, err_len
   );

endinterface

// File: rtl/csi_raw10_unpack.sv
// 2-lane CSI-2 RAW10 payload to RAW8 pixel pairs. Keeps the 8 MSBs of each
// pixel, drops the packed LSB bytes, and checks line alignment and length.
// LINE_PIXELS must be a multiple of 8.
module csi_raw10_unpack
   import csi_raw10_unpack_pkg::*;
#(
   parameter int unsigned LINE_PIXELS = DEFAULT_LINE_PIXELS
) (
   input  logic                clk,
   input  logic                rst,
   csi_raw10_unpack_if.slave   bus
);

   localparam int unsigned WORDS_IN  = LINE_PIXELS * RAW10_GROUP_WORDS / RAW10_GROUP_PIX;
   localparam int unsigned WORDS_OUT = LINE_PIXELS / 2;
   localparam int unsigned IN_CNT_W  = $clog2(WORDS_IN + 1);
   localparam logic [IN_CNT_W-1:0] WORDS_IN_C = IN_CNT_W'(WORDS_IN);

   phase_t              phase;
   logic [7:0]          hold;
   logic [IN_CNT_W-1:0] in_cnt;
   logic                prev_valid;

   logic                out_valid_nxt;
   logic [WORD_W-1:0]   out_data_nxt;

   // Select the pixel pair produced by the current word; lane0 byte is the earlier pixel.
   always_comb begin
      out_valid_nxt = 1'b0;
      out_data_nxt  = '0;
      unique case (phase)
         PH0, PH1: begin
            out_valid_nxt = 1'b1;
            out_data_nxt  = {bus.data_in[7:0], bus.data_in[15:8]};
         end
         PH3, PH4: begin
            out_valid_nxt = 1'b1;
            out_data_nxt  = {hold, bus.data_in[7:0]};
         end
         default: begin
            out_valid_nxt = 1'b0;
            out_data_nxt  = '0;
         end
      endcase
   end

   // Phase/hold/length tracking, registered outputs and sticky error flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase              <= PH0;
         hold               <= '0;
         in_cnt             <= '0;
         prev_valid         <= 1'b0;
         bus.data_out       <= '0;
         bus.data_out_valid <= 1'b0;
         bus.line_done      <= 1'b0;
         bus.err_align      <= 1'b0;
         bus.err_len        <= 1'b0;
      end else begin
         prev_valid         <= bus.data_valid;
         bus.data_out_valid <= 1'b0;
         bus.line_done      <= 1'b0;

         // Clear first so that a new error detected in the same cycle wins.
         if (bus.err_clr) begin
            bus.err_align <= 1'b0;
            bus.err_len   <= 1'b0;
         end

         if (bus.data_valid) begin
            phase <= phase_next(phase);
            if (in_cnt != '1) begin
               in_cnt <= in_cnt + 1'b1;
            end
            // ph2 captures b5, ph3 captures b7; both live in lane1 of the word.
            if ((phase == PH2) || (phase == PH3)) begin
               hold <= bus.data_in[15:8];
            end
            if (out_valid_nxt) begin
               bus.data_out       <= out_data_nxt;
               bus.data_out_valid <= 1'b1;
            end
         end else if (prev_valid) begin
            bus.line_done <= 1'b1;
            if (phase != PH0) begin
               bus.err_align <= 1'b1;
            end
            if (in_cnt != WORDS_IN_C) begin
               bus.err_len <= 1'b1;
            end
            phase  <= PH0;
            in_cnt <= '0;
            hold   <= '0;
         end
      end
   end

endmodule

// File: tb/tb_csi_raw10_unpack.sv
// Scoreboard bench for csi_raw10_unpack: a short-line instance for the directed
// cases and a full-width instance standing in front of a 640-word line consumer.
module tb_csi_raw10_unpack;
   import csi_raw10_unpack_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   csi_raw10_unpack_if bus_a ();
   csi_raw10_unpack_if bus_b ();

   csi_raw10_unpack #(.LINE_PIXELS(16)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   csi_raw10_unpack #(.LINE_PIXELS(1280)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   int n_vec  = 0;
   int n_miss = 0;

   logic [15:0] qa[$];
   logic [1:0]  la[$];
   logic [15:0] qb[$];
   int a_lines = 0;
   int b_lines = 0;
   int b_cnt   = 0;
   int b_wr    = 0;

   // Hand-computed outputs for a line of bytes 0x00, 0x01, 0x02, ...
   logic [15:0] exp_line [10] = '{16'h0001, 16'h0203, 16'h0506, 16'h0708,
                                  16'h0A0B, 16'h0C0D, 16'h0F10, 16'h1112,
                                  16'h1415, 16'h1617};
   // Interrupted line: two words before reset, then the resumed words 3..9.
   logic [15:0] exp_pre  [2]  = '{16'h0001, 16'h0203};
   logic [15:0] exp_post [6]  = '{16'h0607, 16'h0809, 16'h0B0C, 16'h0D0E,
                                  16'h1011, 16'h1213};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] bpat(input int k, input int l);
      return 8'(k * 3 + l * 17);
   endfunction

   task automatic push_a(input int n);
      for (int i = 0; i < n; i++) qa.push_back(exp_line[i]);
   endtask

   task automatic drive_a(input int n, input logic [7:0] base, input logic clr_at_end);
      for (int i = 0; i < n; i++) begin
         bus_a.data_valid = 1'b1;
         bus_a.data_in    = {base + 8'(2 * i + 1), base + 8'(2 * i)};
         @(posedge clk); #1;
      end
      bus_a.data_valid = 1'b0;
      bus_a.err_clr    = clr_at_end;
      @(posedge clk); #1;
      bus_a.err_clr    = 1'b0;
   endtask

   task automatic pulse_clr_a();
      bus_a.err_clr = 1'b1;
      @(posedge clk); #1;
      bus_a.err_clr = 1'b0;
   endtask

   // Monitor for the short-line instance: data order and line-end flag state.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus_a.data_out_valid) begin
            if (qa.size() == 0) begin
               n_vec++; n_miss++;
               $display("FAIL a_unexpected: data_out 0x%0h, expected no output", bus_a.data_out);
            end else begin
               check("a_data", 32'(bus_a.data_out), 32'(qa.pop_front()));
            end
         end
         if (bus_a.line_done) begin
            a_lines++;
            if (la.size() == 0) begin
               n_vec++; n_miss++;
               $display("FAIL a_unexpected_line_done: got 1, expected 0");
            end else begin
               check("a_line_flags", 32'({bus_a.err_align, bus_a.err_len}), 32'(la.pop_front()));
            end
         end
      end
   end

   // Monitor for the full-width instance, with a 640-entry write counter downstream.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus_b.data_out_valid) begin
            if (qb.size() == 0) begin
               n_vec++; n_miss++;
               $display("FAIL b_unexpected: data_out 0x%0h, expected no output", bus_b.data_out);
            end else begin
               check("b_data", 32'(bus_b.data_out), 32'(qb.pop_front()));
            end
            b_cnt++;
            b_wr = (b_wr == 639) ? 0 : b_wr + 1;
         end
         if (bus_b.line_done) begin
            b_lines++;
            check("b_words_per_line", b_cnt, 640);
            check("b_write_count_wrap", b_wr, 0);
            check("b_line_flags", 32'({bus_b.err_align, bus_b.err_len}), 0);
            b_cnt = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus_a.data_in = '0; bus_a.data_valid = 1'b0; bus_a.err_clr = 1'b0;
      bus_b.data_in = '0; bus_b.data_valid = 1'b0; bus_b.err_clr = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("a_reset_state", 32'({bus_a.data_out, bus_a.data_out_valid, bus_a.line_done,
                                  bus_a.err_align, bus_a.err_len}), 0);
      check("b_reset_state", 32'({bus_b.data_out, bus_b.data_out_valid, bus_b.line_done,
                                  bus_b.err_align, bus_b.err_len}), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // One exact-length line.
      push_a(8); la.push_back(2'b00);
      drive_a(10, 8'h00, 1'b0);
      repeat (2) @(posedge clk);
      #1;

      // Three back-to-back lines with single-cycle gaps.
      for (int l = 0; l < 3; l++) begin
         push_a(8); la.push_back(2'b00);
         drive_a(10, 8'h00, 1'b0);
      end

      // Long line ending at phase 2; err_clr coincides with the line end and loses.
      push_a(10); la.push_back(2'b11);
      drive_a(12, 8'h00, 1'b1);
      @(posedge clk); #1;
      check("a_sticky_after_long", 32'({bus_a.err_align, bus_a.err_len}), 32'(2'b11));
      pulse_clr_a();
      check("a_clear_after_long", 32'({bus_a.err_align, bus_a.err_len}), 0);

      // Short line ending at phase 3, then clear.
      push_a(6); la.push_back(2'b11);
      drive_a(8, 8'h00, 1'b0);
      @(posedge clk); #1;
      check("a_sticky_after_short", 32'({bus_a.err_align, bus_a.err_len}), 32'(2'b11));
      pulse_clr_a();
      check("a_clear_after_short", 32'({bus_a.err_align, bus_a.err_len}), 0);

      // Reset after the third word of a line, then resume the remaining seven words.
      for (int i = 0; i < 2; i++) qa.push_back(exp_pre[i]);
      for (int i = 0; i < 3; i++) begin
         bus_a.data_valid = 1'b1;
         bus_a.data_in    = {8'(2 * i + 1), 8'(2 * i)};
         @(posedge clk); #1;
      end
      bus_a.data_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      check("a_mid_line_reset", 32'({bus_a.data_out, bus_a.data_out_valid, bus_a.line_done,
                                     bus_a.err_align, bus_a.err_len}), 0);
      rst = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 6; i++) qa.push_back(exp_post[i]);
      la.push_back(2'b11);
      drive_a(7, 8'h06, 1'b0);

      // Four full-width lines.
      for (int l = 0; l < 4; l++) begin
         for (int g = 0; g < 160; g++) begin
            qb.push_back({bpat(10 * g + 0, l), bpat(10 * g + 1, l)});
            qb.push_back({bpat(10 * g + 2, l), bpat(10 * g + 3, l)});
            qb.push_back({bpat(10 * g + 5, l), bpat(10 * g + 6, l)});
            qb.push_back({bpat(10 * g + 7, l), bpat(10 * g + 8, l)});
         end
         for (int w = 0; w < 800; w++) begin
            bus_b.data_valid = 1'b1;
            bus_b.data_in    = {bpat(2 * w + 1, l), bpat(2 * w, l)};
            @(posedge clk); #1;
         end
         bus_b.data_valid = 1'b0;
         @(posedge clk); #1;
      end

      repeat (5) @(posedge clk);
      #1;
      check("a_queue_drained", qa.size(), 0);
      check("a_line_queue_drained", la.size(), 0);
      check("b_queue_drained", qb.size(), 0);
      check("a_line_done_count", a_lines, 7);
      check("b_line_done_count", b_lines, 4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
